// File: rtl/lsp_pkg.sv
// Shared definitions for the LSP composition block: vector sizes, address
// field widths and the controller state encoding.
package lsp_pkg;

    localparam int M      = 10;   // LSP coefficients per frame
    localparam int MA_NP  = 4;    // MA predictor history depth
    localparam int ADDR_W = 12;   // memory address width
    localparam int J_W    = 4;    // coefficient index field width
    localparam int K_W    = 2;    // history index field width

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MULT   = 3'd1,
        S_MAC    = 3'd2,
        S_WRITE  = 3'd3,
        S_UPD_RD = 3'd4,
        S_UPD_WR = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/lsp_addr_gen.sv
// Address formation for the LSP composition block. Read-side encodings use
// the read indices (rj, rk); write-side encodings use the write indices
// (wj, wk) so the controller can read ahead while writing the current element.
module lsp_addr_gen
    import lsp_pkg::*;
(
    input  logic [ADDR_W-1:0] lspele,
    input  logic [ADDR_W-1:0] freq_prev,
    input  logic [ADDR_W-1:0] lsp,
    input  logic [ADDR_W-1:0] fgAddr,
    input  logic [ADDR_W-1:0] fg_sumAddr,
    input  logic [J_W-1:0]    rj,
    input  logic [K_W-1:0]    rk,
    input  logic [J_W-1:0]    wj,
    input  logic [K_W-1:0]    wk,
    output logic [ADDR_W-1:0] lspele_addr,
    output logic [ADDR_W-1:0] fp_rd_addr,
    output logic [ADDR_W-1:0] fg_addr,
    output logic [ADDR_W-1:0] fg_sum_addr,
    output logic [ADDR_W-1:0] lsp_addr,
    output logic [ADDR_W-1:0] fp_wr_addr
);

    // Low base bits are replaced by the index fields.
    logic unused_s;

    assign lspele_addr = {lspele[11:4], rj};
    assign fp_rd_addr  = {freq_prev[11:6], rj, rk};
    assign fg_addr     = {fgAddr[11:6], rk, rj};
    assign fg_sum_addr = {fg_sumAddr[11:4], rj};
    assign lsp_addr    = {lsp[11:4], wj};
    assign fp_wr_addr  = {freq_prev[11:6], wj, wk};
    assign unused_s    = ^{lspele[3:0], freq_prev[5:0], lsp[3:0], fgAddr[5:0], fg_sumAddr[3:0]};

endmodule

// File: rtl/lsp_prev_compose.sv
// LSP composition from MA prediction: lsp[j] = (lsp_ele[j]*fg_sum[j] +
// sum_k freq_prev[k][j]*fg[k][j]) >> 16, using shared saturating math units
// and synchronous-read scratch/constant memories.
// Optional build macro LSP_PREV_UPDATE_EN adds the freq_prev history shift.
module lsp_prev_compose
    import lsp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    input  logic [11:0] lspele,
    input  logic [11:0] freq_prev,
    input  logic [11:0] lsp,
    input  logic [11:0] fgAddr,
    input  logic [11:0] fg_sumAddr,
    output logic [11:0] readAddr,
    input  logic [31:0] readIn,
    output logic [11:0] writeAddr,
    output logic [31:0] writeOut,
    output logic        writeEn,
    output logic [11:0] constantMemAddr,
    input  logic [31:0] constantMemIn,
    output logic [15:0] L_mult_a,
    output logic [15:0] L_mult_b,
    input  logic [31:0] L_mult_in,
    output logic [15:0] L_mac_a,
    output logic [15:0] L_mac_b,
    output logic [31:0] L_mac_c,
    input  logic [31:0] L_mac_in
);

    state_t      state_r;
    logic [3:0]  j_r;        // 0..10
    logic [2:0]  k_r;        // 0..4
    logic [31:0] acc_r;
    logic        done_r;
    logic        wen_r;

    logic [3:0]  rj_s;
    logic [1:0]  rk_s;
    logic [11:0] lspele_a_s, fp_rd_a_s, fg_a_s, fg_sum_a_s, lsp_a_s, fp_wr_a_s;
    logic        unused_s;

    assign done     = done_r;
    assign writeEn  = wen_r;
    assign unused_s = ^{readIn[31:16], constantMemIn[31:16]};

    lsp_addr_gen u_addr (
        .lspele      (lspele),
        .freq_prev   (freq_prev),
        .lsp         (lsp),
        .fgAddr      (fgAddr),
        .fg_sumAddr  (fg_sumAddr),
        .rj          (rj_s),
        .rk          (rk_s),
        .wj          (j_r),
        .wk          (k_r[1:0]),
        .lspele_addr (lspele_a_s),
        .fp_rd_addr  (fp_rd_a_s),
        .fg_addr     (fg_a_s),
        .fg_sum_addr (fg_sum_a_s),
        .lsp_addr    (lsp_a_s),
        .fp_wr_addr  (fp_wr_a_s)
    );

    // Read-ahead indices: each state addresses the operands of the next state.
    always_comb begin
        rj_s = j_r;
        rk_s = 2'd0;
        case (state_r)
            S_MAC:    rk_s = k_r[1:0] + 2'd1;
            S_WRITE:  rj_s = j_r + 4'd1;
            S_UPD_RD: rk_s = k_r[1:0] - 2'd1;
            default:  rk_s = 2'd0;
        endcase
    end

    // Memory address and write-data selection by state.
    always_comb begin
        readAddr        = 12'h000;
        constantMemAddr = 12'h000;
        writeAddr       = 12'h000;
        writeOut        = 32'h0000_0000;
        case (state_r)
            S_IDLE, S_WRITE: begin
                readAddr        = lspele_a_s;
                constantMemAddr = fg_sum_a_s;
                if (state_r == S_WRITE) begin
                    writeAddr = lsp_a_s;
                    writeOut  = {16'h0000, acc_r[31:16]};
                end else begin
                    writeAddr = 12'h000;
                    writeOut  = 32'h0000_0000;
                end
            end
            S_MULT, S_MAC: begin
                readAddr        = fp_rd_a_s;
                constantMemAddr = fg_a_s;
            end
            S_UPD_RD: begin
                if (k_r == 3'd0) begin
                    readAddr = lspele_a_s;
                end else begin
                    readAddr = fp_rd_a_s;
                end
            end
            S_UPD_WR: begin
                writeAddr = fp_wr_a_s;
                writeOut  = {16'h0000, readIn[15:0]};
            end
            default: begin
                readAddr        = 12'h000;
                constantMemAddr = 12'h000;
            end
        endcase
    end

    // Math operands are driven only in the state that consumes the result.
    always_comb begin
        L_mult_a = 16'h0000;
        L_mult_b = 16'h0000;
        L_mac_a  = 16'h0000;
        L_mac_b  = 16'h0000;
        L_mac_c  = 32'h0000_0000;
        if (state_r == S_MULT) begin
            L_mult_a = readIn[15:0];
            L_mult_b = constantMemIn[15:0];
        end else if (state_r == S_MAC) begin
            L_mac_a = readIn[15:0];
            L_mac_b = constantMemIn[15:0];
            L_mac_c = acc_r;
        end else begin
            L_mult_a = 16'h0000;
            L_mac_c  = 32'h0000_0000;
        end
    end

    // Controller: state, counters, accumulator and registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            j_r     <= 4'd0;
            k_r     <= 3'd0;
            acc_r   <= 32'h0000_0000;
            done_r  <= 1'b0;
            wen_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            wen_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r <= S_MULT;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_MULT: begin
                    acc_r   <= L_mult_in;
                    k_r     <= 3'd0;
                    state_r <= S_MAC;
                end
                S_MAC: begin
                    acc_r <= L_mac_in;
                    k_r   <= k_r + 3'd1;
                    if (k_r == 3'(MA_NP - 1)) begin
                        state_r <= S_WRITE;
                        wen_r   <= 1'b1;
                    end else begin
                        state_r <= S_MAC;
                    end
                end
                S_WRITE: begin
                    j_r <= j_r + 4'd1;
                    if (j_r == 4'(M - 1)) begin
`ifdef LSP_PREV_UPDATE_EN
                        j_r     <= 4'd0;
                        k_r     <= 3'(MA_NP - 1);
                        state_r <= S_UPD_RD;
`else
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
`endif
                    end else begin
                        state_r <= S_MULT;
                    end
                end
`ifdef LSP_PREV_UPDATE_EN
                S_UPD_RD: begin
                    wen_r   <= 1'b1;
                    state_r <= S_UPD_WR;
                end
                S_UPD_WR: begin
                    if (j_r == 4'(M - 1)) begin
                        j_r <= 4'd0;
                        if (k_r == 3'd0) begin
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            k_r     <= k_r - 3'd1;
                            state_r <= S_UPD_RD;
                        end
                    end else begin
                        j_r     <= j_r + 4'd1;
                        state_r <= S_UPD_RD;
                    end
                end
`endif
                S_DONE: begin
                    j_r     <= 4'd0;
                    k_r     <= 3'd0;
                    state_r <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsp_prev_compose.sv
// Scoreboard bench for lsp_prev_compose (default build, history update off).
module tb_lsp_prev_compose;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic [11:0] lspele     = 12'h100;
    logic [11:0] freq_prev  = 12'h200;
    logic [11:0] lsp        = 12'h300;
    logic [11:0] fgAddr     = 12'h400;
    logic [11:0] fg_sumAddr = 12'h500;
    logic [11:0] readAddr;
    logic [31:0] readIn;
    logic [11:0] writeAddr;
    logic [31:0] writeOut;
    logic        writeEn;
    logic [11:0] constantMemAddr;
    logic [31:0] constantMemIn;
    logic [15:0] L_mult_a, L_mult_b, L_mac_a, L_mac_b;
    logic [31:0] L_mult_in, L_mac_c, L_mac_in;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          cycle;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    int  n_checks = 0;
    int  n_err    = 0;
    int  cyc      = 0;
    wr_t mon_e;
    int  mon_d;

    logic [31:0] smem [0:4095];
    logic [31:0] cmem [0:4095];

    always #5 clk = ~clk;

    function automatic logic [31:0] l_mult(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        if (a == 16'h8000 && b == 16'h8000) return 32'h7FFF_FFFF;
        p = $signed(a) * $signed(b);
        return p <<< 1;
    endfunction

    function automatic logic [31:0] l_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return s[31:0];
    endfunction

    assign L_mult_in = l_mult(L_mult_a, L_mult_b);
    assign L_mac_in  = l_add(L_mac_c, l_mult(L_mac_a, L_mac_b));

    // Synchronous-read memories and the cycle counter.
    always @(posedge clk) begin
        cyc           <= cyc + 1;
        readIn        <= smem[readAddr];
        constantMemIn <= cmem[constantMemAddr];
    end

    lsp_prev_compose dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .lspele(lspele), .freq_prev(freq_prev), .lsp(lsp),
        .fgAddr(fgAddr), .fg_sumAddr(fg_sumAddr),
        .readAddr(readAddr), .readIn(readIn),
        .writeAddr(writeAddr), .writeOut(writeOut), .writeEn(writeEn),
        .constantMemAddr(constantMemAddr), .constantMemIn(constantMemIn),
        .L_mult_a(L_mult_a), .L_mult_b(L_mult_b), .L_mult_in(L_mult_in),
        .L_mac_a(L_mac_a), .L_mac_b(L_mac_b), .L_mac_c(L_mac_c), .L_mac_in(L_mac_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every write and done pulse must match the queue head.
    always @(negedge clk) begin
        if (writeEn === 1'b1) begin
            if (wq.size() == 0) begin
                check("unexpected_write", {20'h0, writeAddr}, 32'hFFFF_FFFF);
            end else begin
                mon_e = wq.pop_front();
                check("wr_addr", {20'h0, writeAddr}, {20'h0, mon_e.addr});
                check("wr_data", writeOut, mon_e.data);
                check("wr_cycle", cyc, mon_e.cycle);
            end
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_d = dq.pop_front();
                check("done_cycle", cyc, mon_d);
            end
        end
    end

    function automatic logic [15:0] ref_lsp(input int j);
        logic [31:0] acc;
        acc = l_mult(smem[12'h100 + j][15:0], cmem[12'h500 + j][15:0]);
        for (int k = 0; k < 4; k++)
            acc = l_add(acc, l_mult(smem[12'h200 + 4*j + k][15:0], cmem[12'h400 + 16*k + j][15:0]));
        return acc[31:16];
    endfunction

    // rnd bits: 0 lsp_ele, 1 fg_sum, 2 freq_prev, 3 fg. Upper halves carry junk.
    task automatic setup(input logic [15:0] le, input logic [15:0] fs, input logic [15:0] fp,
                         input logic [15:0] fg, input logic [3:0] rnd);
        for (int j = 0; j < 10; j++) begin
            smem[12'h100 + j] = rnd[0] ? $urandom() : {16'hA5A5, le};
            cmem[12'h500 + j] = rnd[1] ? $urandom() : {16'h5A5A, fs};
            for (int k = 0; k < 4; k++) begin
                smem[12'h200 + 4*j + k] = rnd[2] ? $urandom() : {16'hC3C3, fp};
                cmem[12'h400 + 16*k + j] = rnd[3] ? $urandom() : {16'h3C3C, fg};
            end
        end
    endtask

    task automatic push_frame(input int t0, input bit fixed, input logic [15:0] val,
                              input int n_wr, input bit with_done);
        wr_t w;
        for (int j = 0; j < n_wr; j++) begin
            w.addr  = 12'(12'h300 + j);
            w.data  = {16'h0000, fixed ? val : ref_lsp(j)};
            w.cycle = t0 + 6 * (j + 1);
            wq.push_back(w);
        end
        if (with_done) dq.push_back(t0 + 61);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while ((wq.size() != 0 || dq.size() != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        check("pending_after_frame", wq.size() + dq.size(), 32'd0);
    endtask

    task automatic run_frame(input bit fixed, input logic [15:0] val);
        int t0;
        @(negedge clk);
        t0 = cyc;
        push_frame(t0, fixed, val, 10, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(200);
    endtask

    initial begin
        int t0;
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            smem[i] = 32'h0;
            cmem[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_wen", {31'h0, writeEn}, 32'd0);
        check("rst_rdaddr", {20'h0, readAddr}, 32'h100);
        check("rst_cmaddr", {20'h0, constantMemAddr}, 32'h500);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Zero case, multiply only, accumulation, saturation.
        setup(16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1010);
        run_frame(1'b1, 16'h0000);
        setup(16'h4000, 16'h7FFF, 16'h0000, 16'h0000, 4'b1000);
        run_frame(1'b1, 16'h3FFF);
        setup(16'h0000, 16'h0000, 16'h2000, 16'h2000, 4'b0010);
        run_frame(1'b1, 16'h2000);
        setup(16'h8000, 16'h8000, 16'h4000, 16'h4000, 4'b0000);
        run_frame(1'b1, 16'h7FFF);

        // Random data against the reference model.
        for (int r = 0; r < 2; r++) begin
            setup(16'h0, 16'h0, 16'h0, 16'h0, 4'b1111);
            run_frame(1'b0, 16'h0);
        end

        // Abort: reset at cycle 20 of a frame; only writes 0..2 may appear.
        setup(16'h0, 16'h0, 16'h0, 16'h0, 4'b1111);
        @(negedge clk);
        t0 = cyc;
        push_frame(t0, 1'b0, 16'h0, 3, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (80) @(negedge clk);
        check("abort_pending", wq.size() + dq.size(), 32'd0);
        check("abort_rdaddr", {20'h0, readAddr}, 32'h100);
        setup(16'h0, 16'h0, 16'h0, 16'h0, 4'b1111);
        run_frame(1'b0, 16'h0);

        // Start held high: second frame begins the cycle after DONE.
        setup(16'h0, 16'h0, 16'h0, 16'h0, 4'b1111);
        @(negedge clk);
        t0 = cyc;
        push_frame(t0, 1'b0, 16'h0, 10, 1'b1);
        push_frame(t0 + 62, 1'b0, 16'h0, 10, 1'b1);
        start = 1'b1;
        repeat (70) @(negedge clk);
        start = 1'b0;
        wait_idle(200);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
